// File: rtl/color_scan_if.sv
// Colour-sensor scan bus.
// Groups the sensor-side pins (sensor in, filter_sel/scale out) and the
// controller-side handshake/results (start, abort, busy, done, cnt_*).
//   slave  : view used by color_scan_ctrl
//   master : view used by whoever drives the scan (classifier or bench)
interface color_scan_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sensor;
  logic             start;
  logic             abort;
  logic [1:0]       filter_sel;
  logic [1:0]       scale;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt_red;
  logic [CNT_W-1:0] cnt_blue;
  logic [CNT_W-1:0] cnt_clear;
  logic [CNT_W-1:0] cnt_green;

  modport slave (
    input  sensor, start, abort,
    output filter_sel, scale, busy, done, cnt_red, cnt_blue, cnt_clear, cnt_green
  );

  modport master (
    output sensor, start, abort,
    input  filter_sel, scale, busy, done, cnt_red, cnt_blue, cnt_clear, cnt_green
  );
endinterface

// File: rtl/color_scan_ctrl.sv
// Four-filter colour sensor scan sequencer.
// Steps filter_sel through red, blue, clear, green; per filter waits SETTLE_CYC
// cycles, then counts sensor rising edges for GATE_CYC cycles. All four counts
// are published together with a one-cycle done pulse.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - color_scan_if slave: sensor/start/abort in; filter_sel, scale,
//          busy, done, cnt_red/blue/clear/green out
module color_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned GATE_CYC   = 100000,
  parameter int unsigned CNT_W      = 16,
  parameter logic [1:0]  SCALE      = 2'b11,
  parameter bit          PWRDN_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  color_scan_if.slave  bus
);

  localparam int unsigned TmrMax = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0]  SettleLast = TmrW'(SETTLE_CYC - 1);
  localparam logic [TmrW-1:0]  GateLast   = TmrW'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [1:0]       IdleScale  = PWRDN_IDLE ? 2'b00 : SCALE;

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

  state_e                    state_q, state_d;
  logic [TmrW-1:0]           timer_q, timer_d;
  logic [CNT_W-1:0]          edge_cnt_q, edge_cnt_d;
  logic [1:0]                fsel_q, fsel_d;
  logic [3:0][CNT_W-1:0]     shadow_q, shadow_d;
  logic [3:0][CNT_W-1:0]     cnt_q, cnt_d;
  // [0],[1] synchronize the async sensor; [2] is the edge-detect history.
  logic [2:0]                sync_q;
  logic                      sens_rise;
  logic [CNT_W-1:0]          edge_sum;

  assign sens_rise = sync_q[1] & ~sync_q[2];
  assign edge_sum  = (sens_rise && (edge_cnt_q != CntMax)) ? edge_cnt_q + 1'b1 : edge_cnt_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    fsel_d     = fsel_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          fsel_d  = 2'b00;
          timer_d = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          fsel_d  = 2'b00;
          state_d = StIdle;
        end else if (timer_q == SettleLast) begin
          timer_d    = '0;
          edge_cnt_d = '0;
          state_d    = StGate;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGate: begin
        if (bus.abort) begin
          fsel_d  = 2'b00;
          state_d = StIdle;
        end else begin
          edge_cnt_d = edge_sum;
          if (timer_q == GateLast) begin
            // edge_sum includes an edge landing on the final gate cycle
            shadow_d[fsel_q] = edge_sum;
            timer_d          = '0;
            if (fsel_q == 2'b11) begin
              // Results are loaded on the edge entering DONE so they are
              // already valid in the same cycle that done is high.
              cnt_d   = shadow_d;
              state_d = StDone;
            end else begin
              fsel_d  = fsel_q + 2'd1;
              state_d = StSettle;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StDone: begin
        fsel_d  = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      fsel_q     <= 2'b00;
      shadow_q   <= '0;
      cnt_q      <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      fsel_q     <= fsel_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      sync_q     <= {sync_q[1:0], bus.sensor};
    end
  end

  assign bus.busy       = (state_q == StSettle) || (state_q == StGate);
  assign bus.done       = (state_q == StDone);
  assign bus.filter_sel = fsel_q;
  assign bus.scale      = bus.busy ? SCALE : IdleScale;
  assign bus.cnt_red    = cnt_q[0];
  assign bus.cnt_blue   = cnt_q[1];
  assign bus.cnt_clear  = cnt_q[2];
  assign bus.cnt_green  = cnt_q[3];

endmodule

// File: doc/color_scan_ctrl.md
# color_scan_ctrl

Sequencer for the four-filter photodiode colour sensor front end. It steps the sensor's filter select through red, blue, clear and green. For each filter it waits a settling interval, then counts rising edges of the sensor's frequency output over a fixed gate window. When all four counts are taken it publishes them together with a one-cycle completion pulse. It sits between the sensor pins and the colour-classification logic.

## Interface
Parameters:
- SETTLE_CYC, default 1000: clk cycles to wait after each filter change before counting (≥1).
- GATE_CYC, default 100000: clk cycles of the edge-counting window per filter (≥1).
- CNT_W, default 16: width of each result count.
- SCALE, default 2'b11: frequency-scaling pins {S0,S1} driven while scanning.
- PWRDN_IDLE, default 1: when 1, scale is driven 2'b00 (sensor power-down) outside a scan.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- sensor, input, 1: sensor frequency output, asynchronous to clk.
- start, input, 1: scan request, sampled only in IDLE.
- abort, input, 1: synchronous scan cancel.
- filter_sel, output, 2: {S2,S3}. 00 red, 01 blue, 10 clear, 11 green.
- scale, output, 2: {S0,S1}.
- busy, output, 1: high from the cycle after start is accepted until DONE.
- done, output, 1: one-cycle pulse when the results update.
- cnt_red, cnt_blue, cnt_clear, cnt_green, output, CNT_W each: latest completed results.

## Operation
- Sensor input: 2-flop synchronizer, then a third flop for edge detection. An edge is sync2 & ~sync3, giving 2–3 cycles of input latency.
- FSM states: IDLE, SETTLE, GATE, DONE.
  - IDLE, start=1: filter_sel←00, timer←0, go to SETTLE.
  - SETTLE: timer increments each cycle. When timer==SETTLE_CYC-1, timer←0, edge_cnt←0, go to GATE.
  - GATE: edge_cnt increments on each detected edge and saturates at 2^CNT_W-1. An edge on the last cycle (timer==GATE_CYC-1) is included.
    - On the last cycle, the final count is written to the shadow register for the current filter.
    - If filter_sel==11, go to DONE. Otherwise filter_sel+1, timer←0, go to SETTLE.
  - DONE: copy all four shadow registers to the cnt_* outputs, assert done for 1 cycle, filter_sel←00, go to IDLE.
- Output registers change only in DONE. Partial scans never alter them.
- abort=1 in SETTLE or GATE: go to IDLE next cycle, filter_sel←00, no done, cnt_* unchanged. abort takes priority over the state's normal transition. abort in IDLE or DONE has no effect.
- start while not in IDLE is ignored. start held high re-arms a new scan on the cycle after DONE.
- Timer width is clog2(max(SETTLE_CYC, GATE_CYC)).

## Timing
- Reset values: filter_sel=00, busy=0, done=0, all cnt_*=0, state IDLE. scale=00 if PWRDN_IDLE=1, otherwise SCALE.
- scale=SCALE while busy.
- Latency: start sampled in IDLE at cycle 0. done is high at cycle 4·(SETTLE_CYC+GATE_CYC)+1, and cnt_* are valid from that same cycle.
- filter_sel changes on the clock edge that enters SETTLE, so the sensor always gets a full SETTLE_CYC before counting.
- Reset asserted mid-scan returns all outputs to reset values immediately, without waiting for a clock edge.

## Test plan
All scenarios use SETTLE_CYC=4, GATE_CYC=20, CNT_W=4 unless stated.
- Reset, no start → all outputs 0, busy=0, scale=00.
- start pulse, sensor period 4 (2 high/2 low) → busy next cycle; done at cycle 97; all four counts =5; filter_sel sequence 00,01,10,11,00.
- Sensor period chosen per filter_sel (red 2, blue 4, clear 5, green 10) → cnt_red=10, cnt_blue=5, cnt_clear=4, cnt_green=2.
- CNT_W=3, red period 2 → cnt_red=7 (saturated, no wrap).
- After a completed scan, abort mid-GATE of blue → busy=0 next cycle, no done, cnt_* keep the prior values, filter_sel=00. A start pulsed during busy causes no second scan.
- Async rst mid-SETTLE of clear → outputs zero before the next clk edge. A new start then yields a full, correct scan.
